// File: rtl/fetch_pkg.sv
// Shared constants and the queued entry type for the instruction fetch block.
package fetch_pkg;

    localparam int FETCH_PC_W   = 16;
    localparam int FETCH_INST_W = 32;
    localparam int FETCH_DEPTH  = 4;

    // One fetched instruction together with the address it was read from.
    typedef struct packed {
        logic [FETCH_PC_W-1:0]   pc;
        logic [FETCH_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through queue with synchronous flush and a count output.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_pop;
    logic             do_push;

    // A push into a full queue is only accepted when a pop frees a slot.
    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != FULL) || do_pop);
    end

    // Pointer and count bookkeeping; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-based request issue, redirect/kill handling
// and a small queue feeding decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = FETCH_PC_W,
    parameter int              INST_W   = FETCH_INST_W,
    parameter int              DEPTH    = FETCH_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic [PC_W-1:0]          im_addr,
    output logic                     im_req,
    input  logic [INST_W-1:0]        im_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [PC_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]        inflight_pc_q, inflight_pc_d;
    logic                   inflight_q, inflight_d;

    logic [PC_W-1:0]        redirect_aligned;
    logic                   redirect_eff;
    logic [CW-1:0]          fifo_count;
    logic [PC_W+INST_W-1:0] fifo_dout;
    logic                   fifo_push;
    logic                   pop;
    logic [CW:0]            demand;

    // Issue, credit and output qualification for the current cycle.
    always_comb begin
        redirect_aligned = redirect_pc & ~PC_W'(3);
        redirect_eff     = redirect && !rst;
        out_valid        = !rst && (fifo_count != '0) && !redirect;
        pop              = out_valid && out_ready;
        // Entries that will be held after this edge, counting the response still due.
        demand           = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        im_req           = !rst && (redirect || (demand < DEPTH_C));
        im_addr          = redirect_eff ? redirect_aligned : fetch_pc_q;
        // A response returning in a redirect cycle belongs to the killed stream.
        fifo_push        = inflight_q && !redirect_eff;
        out_pc           = out_valid ? fifo_dout[PC_W+INST_W-1:INST_W] : '0;
        out_inst         = out_valid ? fifo_dout[INST_W-1:0] : '0;
        occupancy        = rst ? '0 : fifo_count;
    end

    // Next fetch address and in-flight tracking.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = im_req;
        inflight_pc_d = im_addr;
        if (redirect_eff) begin
            fetch_pc_d = redirect_aligned + PC_W'(4);
        end else if (im_req) begin
            fetch_pc_d = fetch_pc_q + PC_W'(4);
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    sync_fifo #(
        .WIDTH (PC_W + INST_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_eff),
        .push  (fifo_push),
        .din   ({inflight_pc_q, im_rdata}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// redirect/reset sequences and randomized traffic against a queue-based model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] im_addr;
    logic        im_req;
    logic [31:0] im_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  occupancy;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_addr     (im_addr),
        .im_req      (im_req),
        .im_rdata    (im_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {~a, a};
    endfunction

    // Instruction memory: data one cycle after the request, junk otherwise.
    always @(posedge clk) im_rdata <= im_req ? mem_word(im_addr) : $urandom;

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Reference model state: decoded queue, one outstanding read, next address.
    fetch_entry_t mq[$];
    bit           m_inf = 0;
    logic [15:0]  m_inf_pc = '0;
    logic [15:0]  m_pc = '0;
    int           cyc = 0;

    logic        s_valid, s_req;
    logic [15:0] s_pc, s_addr;
    logic [31:0] s_inst;
    logic [2:0]  s_occ;

    task automatic step(input bit r, input bit rd, input logic [15:0] rp, input bit rdy);
        bit          e_valid, e_pop, e_req;
        logic [15:0] e_addr, e_pc;
        logic [31:0] e_inst;
        int          held;
        rst = r; redirect = rd; redirect_pc = rp; out_ready = rdy;
        @(negedge clk);
        e_valid = !r && (mq.size() != 0) && !rd;
        e_pop   = e_valid && rdy;
        held    = mq.size() + int'(m_inf) - int'(e_pop);
        e_req   = !r && (rd || held < DEPTH);
        e_addr  = rd ? (rp & 16'hFFFC) : m_pc;
        e_pc    = e_valid ? mq[0].pc : 16'h0;
        e_inst  = e_valid ? mq[0].inst : 32'h0;
        s_valid = out_valid; s_req = im_req; s_pc = out_pc; s_addr = im_addr;
        s_inst = out_inst; s_occ = occupancy;
        check($sformatf("c%0d out_valid", cyc), {31'b0, s_valid}, {31'b0, e_valid});
        check($sformatf("c%0d im_req", cyc), {31'b0, s_req}, {31'b0, e_req});
        if (e_req) check($sformatf("c%0d im_addr", cyc), {16'b0, s_addr}, {16'b0, e_addr});
        check($sformatf("c%0d out_pc", cyc), {16'b0, s_pc}, {16'b0, e_pc});
        check($sformatf("c%0d out_inst", cyc), s_inst, e_inst);
        check($sformatf("c%0d occupancy", cyc), {29'b0, s_occ}, r ? 32'd0 : 32'(mq.size()));
        if (s_valid && rdy) $display("c%0d deliver pc=0x%04h inst=0x%08h", cyc, s_pc, s_inst);
        if (r) begin
            mq.delete(); m_inf = 0; m_pc = 16'h0;
        end else if (rd) begin
            mq.delete(); m_inf = 1; m_inf_pc = rp & 16'hFFFC; m_pc = (rp & 16'hFFFC) + 16'd4;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (m_inf) mq.push_back('{pc: m_inf_pc, inst: mem_word(m_inf_pc)});
            m_inf = e_req; m_inf_pc = m_pc;
            if (e_req) m_pc = m_pc + 16'd4;
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          rst;
        bit          rd;
        logic [15:0] rp;
        bit          rdy;
        bit          e_req;
        logic [15:0] e_addr;
        bit          e_valid;
        logic [15:0] e_pc;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit rdy, bit q, logic [15:0] a, bit v, logic [15:0] p, logic [2:0] o);
        vec_t t;
        t.rst = r; t.rd = 0; t.rp = '0; t.rdy = rdy;
        t.e_req = q; t.e_addr = a; t.e_valid = v; t.e_pc = p; t.e_occ = o;
        return t;
    endfunction

    initial begin
        // Streaming from reset with decode always ready.
        vecs.push_back(mk(1, 1, 0, 16'h0,  0, 16'h0,  3'd0));
        vecs.push_back(mk(0, 1, 1, 16'h0,  0, 16'h0,  3'd0));
        vecs.push_back(mk(0, 1, 1, 16'h4,  0, 16'h0,  3'd0));
        vecs.push_back(mk(0, 1, 1, 16'h8,  1, 16'h0,  3'd1));
        vecs.push_back(mk(0, 1, 1, 16'hC,  1, 16'h4,  3'd1));
        vecs.push_back(mk(0, 1, 1, 16'h10, 1, 16'h8,  3'd1));
        // Decode stalled from reset: queue saturates, then drains in order.
        vecs.push_back(mk(1, 0, 0, 16'h0,  0, 16'h0,  3'd0));
        vecs.push_back(mk(0, 0, 1, 16'h0,  0, 16'h0,  3'd0));
        vecs.push_back(mk(0, 0, 1, 16'h4,  0, 16'h0,  3'd0));
        vecs.push_back(mk(0, 0, 1, 16'h8,  1, 16'h0,  3'd1));
        vecs.push_back(mk(0, 0, 1, 16'hC,  1, 16'h0,  3'd2));
        vecs.push_back(mk(0, 0, 0, 16'h0,  1, 16'h0,  3'd3));
        vecs.push_back(mk(0, 0, 0, 16'h0,  1, 16'h0,  3'd4));
        vecs.push_back(mk(0, 0, 0, 16'h0,  1, 16'h0,  3'd4));
        vecs.push_back(mk(0, 1, 1, 16'h10, 1, 16'h0,  3'd4));
        vecs.push_back(mk(0, 1, 1, 16'h14, 1, 16'h4,  3'd3));
        vecs.push_back(mk(0, 1, 1, 16'h18, 1, 16'h8,  3'd3));
        vecs.push_back(mk(0, 1, 1, 16'h1C, 1, 16'hC,  3'd3));
        vecs.push_back(mk(0, 1, 1, 16'h20, 1, 16'h10, 3'd3));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].rd, vecs[i].rp, vecs[i].rdy);
            check($sformatf("vec%0d req", i), {31'b0, s_req}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req) check($sformatf("vec%0d addr", i), {16'b0, s_addr}, {16'b0, vecs[i].e_addr});
            check($sformatf("vec%0d valid", i), {31'b0, s_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("vec%0d pc", i), {16'b0, s_pc}, {16'b0, vecs[i].e_pc});
            check($sformatf("vec%0d occ", i), {29'b0, s_occ}, {29'b0, vecs[i].e_occ});
        end

        // Redirect with three queued entries and one read outstanding.
        step(1, 0, 16'h0, 0);
        repeat (4) step(0, 0, 16'h0, 0);
        step(0, 1, 16'h0103, 1);
        check("rd1 occ_before", {29'b0, s_occ}, 32'd3);
        check("rd1 valid_in_redirect", {31'b0, s_valid}, 32'd0);
        check("rd1 addr", {16'b0, s_addr}, 32'h0100);
        step(0, 0, 16'h0, 1);
        check("rd1 occ_after", {29'b0, s_occ}, 32'd0);
        check("rd1 valid_after", {31'b0, s_valid}, 32'd0);
        step(0, 0, 16'h0, 1);
        check("rd1 first_pc", {15'b0, s_valid, s_pc}, 32'h1_0100);
        step(0, 0, 16'h0, 1);
        check("rd1 second_pc", {15'b0, s_valid, s_pc}, 32'h1_0104);

        // Back-to-back redirects: only the second stream survives.
        step(0, 1, 16'h0040, 1);
        step(0, 1, 16'h0080, 1);
        step(0, 0, 16'h0, 1);
        check("rd2 gap", {31'b0, s_valid}, 32'd0);
        step(0, 0, 16'h0, 1);
        check("rd2 first_pc", {15'b0, s_valid, s_pc}, 32'h1_0080);
        step(0, 0, 16'h0, 1);
        check("rd2 second_pc", {15'b0, s_valid, s_pc}, 32'h1_0084);

        // Address wrap at the top of the PC range.
        step(0, 1, 16'hFFF8, 1);
        step(0, 0, 16'h0, 1);
        step(0, 0, 16'h0, 1);
        check("wrap pc0", {15'b0, s_valid, s_pc}, 32'h1_FFF8);
        step(0, 0, 16'h0, 1);
        check("wrap pc1", {15'b0, s_valid, s_pc}, 32'h1_FFFC);
        step(0, 0, 16'h0, 1);
        check("wrap pc2", {15'b0, s_valid, s_pc}, 32'h1_0000);

        // Reset together with a redirect while the queue is full.
        repeat (6) step(0, 0, 16'h0, 0);
        check("rst full_before", {29'b0, s_occ}, 32'd4);
        step(1, 1, 16'h0200, 0);
        check("rst valid", {31'b0, s_valid}, 32'd0);
        check("rst req", {31'b0, s_req}, 32'd0);
        check("rst occ", {29'b0, s_occ}, 32'd0);
        step(1, 0, 16'h0, 1);
        check("rst valid2", {31'b0, s_valid}, 32'd0);
        step(0, 0, 16'h0, 1);
        check("rst restart_req", {15'b0, s_req, s_addr}, 32'h1_0000);
        check("rst restart_valid", {31'b0, s_valid}, 32'd0);
        step(0, 0, 16'h0, 1);
        check("rst gap", {31'b0, s_valid}, 32'd0);
        step(0, 0, 16'h0, 1);
        check("rst first_pc", {15'b0, s_valid, s_pc}, 32'h1_0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(99) == 0, $urandom_range(19) == 0,
                 16'($urandom), $urandom_range(9) < 7);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
